// File: rtl/uart_pwm_multichannel_pkg.sv
// Shared types and constants for the UART-to-PWM bridge.
package uart_pwm_pkg;

  localparam logic [3:0] ADDR_TAG = 4'hA;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } rx_state_t;

  typedef enum logic {
    P_ADDR = 1'b0,
    P_DUTY = 1'b1
  } parser_state_t;

  // Five-bit compare so NUM_CH = 16 still admits channel 15.
  function automatic logic addr_valid(input logic [7:0] b, input logic [4:0] num_ch);
    return (b[7:4] == ADDR_TAG) && ({1'b0, b[3:0]} < num_ch);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop synchroniser, falling-edge start detect,
// mid-bit sampling, registered byte / valid / framing-error outputs.
module uart_rx_core
  import uart_pwm_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_dv,
  output logic       o_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

  rx_state_t     r_state;
  rx_state_t     w_next;
  logic          r_meta;
  logic          r_sync;
  logic          r_prev;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_byte;
  logic          r_dv;
  logic          r_frame_err;
  logic          w_fall;
  logic          w_tick;
  logic          w_stop_ok;
  logic          w_stop_bad;

  // Synchroniser flops reset high so a reset release never looks like a start edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_fall) w_next = START;
        else        w_next = IDLE;
      end
      START: begin
        if (w_tick) w_next = r_sync ? IDLE : DATA;
        else        w_next = START;
      end
      DATA: begin
        if (w_tick && (r_bit_idx == 3'd7)) w_next = STOP;
        else                               w_next = DATA;
      end
      STOP: begin
        if (w_tick) w_next = CLEANUP;
        else        w_next = STOP;
      end
      CLEANUP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_fall     = r_prev & ~r_sync;
    w_tick     = 1'b0;
    w_stop_ok  = 1'b0;
    w_stop_bad = 1'b0;
    case (r_state)
      START:   w_tick = (r_cnt == HALF_CNT);
      DATA:    w_tick = (r_cnt == FULL_CNT);
      STOP: begin
        w_tick     = (r_cnt == FULL_CNT);
        w_stop_ok  = w_tick & r_sync;
        w_stop_bad = w_tick & ~r_sync;
      end
      default: w_tick = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      case (r_state)
        START, DATA, STOP: r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
        default:           r_cnt <= '0;
      endcase
      if (r_state == START) begin
        r_bit_idx <= 3'd0;
      end else if ((r_state == DATA) && w_tick) begin
        r_bit_idx <= r_bit_idx + 3'd1;
        r_shift   <= {r_sync, r_shift[7:1]};
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_byte      <= 8'h00;
      r_dv        <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_dv        <= w_stop_ok;
      r_frame_err <= w_stop_bad;
      if (w_stop_ok) r_byte <= r_shift;
    end
  end

  assign o_byte      = r_byte;
  assign o_dv        = r_dv;
  assign o_frame_err = r_frame_err;

endmodule

// File: rtl/uart_pwm_multichannel.sv
// UART command parser feeding NUM_CH double-buffered 8-bit PWM channels;
// duties move from shadow to active only when the PWM counter wraps.
module uart_pwm_multichannel
  import uart_pwm_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int NUM_CH       = 4,
  parameter int PWM_PRESCALE = 1,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_RX_SerialBus,
  output logic              o_RX_DV,
  output logic [7:0]        o_RX_Data,
  output logic              o_Frame_Err,
  output logic              o_Cmd_Err,
  output logic [NUM_CH-1:0] o_pwm
);

  localparam int TO_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO_CLKS + 1);
  localparam int PW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TO_CLKS - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PWM_PRESCALE - 1);
  localparam logic [4:0]    NUM_CH_5 = 5'(NUM_CH);

  logic          w_dv;
  logic          w_frame_err;
  logic [7:0]    w_byte;
  parser_state_t r_pstate;
  parser_state_t w_pnext;
  logic [3:0]    r_ch;
  logic [TW-1:0] r_to_cnt;
  logic          w_addr_ok;
  logic          w_timeout;
  logic          w_latch_ch;
  logic          w_write;
  logic          w_cmd_err;
  logic          r_cmd_err;
  logic [7:0]    r_shadow [NUM_CH];
  logic [7:0]    r_active [NUM_CH];
  logic [PW-1:0] r_pre;
  logic [7:0]    r_pwm_cnt;
  logic          w_step;
  logic          w_wrap;
  logic [NUM_CH-1:0] r_pwm;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_clk      (i_Clock),
    .i_rst      (i_Reset),
    .i_rx       (i_RX_SerialBus),
    .o_byte     (w_byte),
    .o_dv       (w_dv),
    .o_frame_err(w_frame_err)
  );

  assign w_addr_ok = addr_valid(w_byte, NUM_CH_5);
  assign w_timeout = (r_to_cnt == TO_LAST);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) r_pstate <= P_ADDR;
    else         r_pstate <= w_pnext;
  end

  // A framing error always drops any half-received command.
  always_comb begin
    w_pnext = r_pstate;
    case (r_pstate)
      P_ADDR: begin
        if (w_dv && w_addr_ok) w_pnext = P_DUTY;
        else                   w_pnext = P_ADDR;
      end
      P_DUTY: begin
        if (w_dv || w_frame_err || w_timeout) w_pnext = P_ADDR;
        else                                  w_pnext = P_DUTY;
      end
      default: w_pnext = P_ADDR;
    endcase
  end

  always_comb begin
    w_latch_ch = 1'b0;
    w_write    = 1'b0;
    w_cmd_err  = 1'b0;
    case (r_pstate)
      P_ADDR: begin
        w_latch_ch = w_dv & w_addr_ok;
        w_cmd_err  = w_dv & ~w_addr_ok;
      end
      P_DUTY: begin
        w_write   = w_dv;
        w_cmd_err = w_timeout & ~w_dv & ~w_frame_err;
      end
      default: begin
        w_latch_ch = 1'b0;
        w_write    = 1'b0;
        w_cmd_err  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_to_cnt  <= '0;
      r_ch      <= 4'd0;
      r_cmd_err <= 1'b0;
    end else begin
      r_cmd_err <= w_cmd_err;
      if (w_latch_ch) begin
        r_to_cnt <= '0;
        r_ch     <= w_byte[3:0];
      end else if ((r_pstate == P_DUTY) && !w_timeout) begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end
    end
  end

  assign w_step = (r_pre == PRE_LAST);
  assign w_wrap = w_step && (r_pwm_cnt == 8'hFF);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_pre     <= '0;
      r_pwm_cnt <= 8'h00;
    end else begin
      r_pre <= w_step ? '0 : r_pre + PW'(1);
      if (w_step) r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end
  end

  // A shadow write landing on the wrap cycle bypasses straight into active.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      for (int n = 0; n < NUM_CH; n++) begin
        r_shadow[n] <= 8'h00;
        r_active[n] <= 8'h00;
      end
      r_pwm <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (w_write && (r_ch == 4'(n))) r_shadow[n] <= w_byte;
        if (w_wrap) r_active[n] <= (w_write && (r_ch == 4'(n))) ? w_byte : r_shadow[n];
        r_pwm[n] <= (r_pwm_cnt < r_active[n]);
      end
    end
  end

  assign o_RX_DV     = w_dv;
  assign o_RX_Data   = w_byte;
  assign o_Frame_Err = w_frame_err;
  assign o_Cmd_Err   = r_cmd_err;
  assign o_pwm       = r_pwm;

endmodule

// File: tb/tb_uart_pwm_multichannel.sv
// Scoreboard bench: a command-level model predicts UART/parser events and PWM duties.
`timescale 1ns/1ps
module tb_uart_pwm_multichannel;

  localparam int CPB      = 217;
  localparam int NCH      = 4;
  localparam int LONG_GAP = 4400;
  localparam int EV_DV    = 0;
  localparam int EV_CMD   = 1;
  localparam int EV_FRAME = 2;

  typedef struct {
    int kind;
    int data;
  } ev_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           rx  = 1'b1;
  logic           o_RX_DV;
  logic [7:0]     o_RX_Data;
  logic           o_Frame_Err;
  logic           o_Cmd_Err;
  logic [NCH-1:0] o_pwm;

  ev_t exp_q[$];
  int  m_duty[NCH];
  int  m_pending = -1;
  int  total = 0;
  int  bad   = 0;

  uart_pwm_multichannel #(
    .CLKS_PER_BIT(CPB),
    .NUM_CH      (NCH),
    .PWM_PRESCALE(1),
    .TIMEOUT_BITS(20)
  ) dut (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_RX_SerialBus(rx),
    .o_RX_DV       (o_RX_DV),
    .o_RX_Data     (o_RX_Data),
    .o_Frame_Err   (o_Frame_Err),
    .o_Cmd_Err     (o_Cmd_Err),
    .o_pwm         (o_pwm)
  );

  always #20 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input int data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Reference model: a command is "A<ch>" followed by any duty byte.
  task automatic model_byte(input logic [7:0] b);
    push_ev(EV_DV, int'(b));
    if (m_pending >= 0) begin
      m_duty[m_pending] = int'(b);
      m_pending = -1;
    end else if (b[7:4] == 4'hA && int'(b[3:0]) < NCH) begin
      m_pending = int'(b[3:0]);
    end else begin
      push_ev(EV_CMD, 0);
    end
  endtask

  task automatic model_idle(input int clocks);
    if (clocks >= LONG_GAP && m_pending >= 0) begin
      push_ev(EV_CMD, 0);
      m_pending = -1;
    end
  endtask

  task automatic model_frame_err();
    push_ev(EV_FRAME, 0);
    m_pending = -1;
  endtask

  task automatic model_reset();
    for (int n = 0; n < NCH; n++) m_duty[n] = 0;
    m_pending = -1;
    exp_q.delete();
  endtask

  task automatic send_raw(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    model_byte(b);
    send_raw(b, 1'b1);
  endtask

  task automatic idle(input int clocks);
    model_idle(clocks);
    repeat (clocks) @(negedge clk);
  endtask

  // Any 256 consecutive clocks after a wrap hold exactly duty high cycles.
  task automatic check_window(input string tag);
    int cnt[NCH];
    repeat (260) @(negedge clk);
    for (int n = 0; n < NCH; n++) cnt[n] = 0;
    for (int k = 0; k < 256; k++) begin
      for (int n = 0; n < NCH; n++) if (o_pwm[n]) cnt[n]++;
      @(negedge clk);
    end
    for (int n = 0; n < NCH; n++) check($sformatf("%s_duty_ch%0d", tag, n), cnt[n], m_duty[n]);
  endtask

  // First pulse after a 0 -> d change must be full length (no truncation).
  task automatic first_run(input int ch, input int exp);
    int w;
    int n;
    w = 0;
    while (o_pwm[ch] !== 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) begin
      check($sformatf("first_rise_ch%0d", ch), int'(o_pwm[ch]), 1);
    end else begin
      n = 0;
      while (o_pwm[ch] === 1'b1 && n < 400) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("first_run_ch%0d", ch), n, exp);
    end
  endtask

  task automatic take_event(input int kind, input int data);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", kind, -1);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_data", data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (o_RX_DV)     take_event(EV_DV, int'(o_RX_Data));
      if (o_Cmd_Err)   take_event(EV_CMD, 0);
      if (o_Frame_Err) take_event(EV_FRAME, 0);
    end
  end

  initial begin
    #6000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode;
    logic [7:0] b;
    model_reset();
    repeat (5) @(negedge clk);
    check("rst_pwm", int'(o_pwm), 0);
    check("rst_dv", int'(o_RX_DV), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_pwm", int'(o_pwm), 0);
    check("idle_data", int'(o_RX_Data), 0);
    check("idle_errs", int'({o_Frame_Err, o_Cmd_Err}), 0);

    // 1: channel 1 to 128/256
    send(8'hA1);
    repeat (20) @(negedge clk);
    model_byte(8'h80);
    fork
      send_raw(8'h80, 1'b1);
      first_run(1, 128);
    join
    check_window("t1");

    // 2: channel 0 to 0 then 255
    send(8'hA0);
    send(8'h00);
    check_window("t2a");
    send(8'hA0);
    model_byte(8'hFF);
    fork
      send_raw(8'hFF, 1'b1);
      first_run(0, 255);
    join
    check_window("t2b");

    // 3: illegal address bytes, then channel 2 to 64
    send(8'hB2);
    idle(30);
    send(8'hA5);
    idle(30);
    send(8'hA2);
    send(8'h40);
    check_window("t3");

    // 4: address then timeout; the late byte becomes an address
    send(8'hA3);
    idle(LONG_GAP);
    send(8'h40);
    check_window("t4");

    // 5: framing error, then a short glitch
    model_frame_err();
    send_raw(8'hA0, 1'b0);
    idle(200);
    rx = 1'b0;
    #2000;
    @(negedge clk);
    rx = 1'b1;
    idle(3000);
    check("queue_drained", exp_q.size(), 0);

    // 6: reset mid-frame and mid-period
    rx = 1'b0;
    repeat (500) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_pwm", int'(o_pwm), 0);
    check("midrst_dv", int'(o_RX_DV), 0);
    model_reset();
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send(8'hA1);
    model_byte(8'h20);
    fork
      send_raw(8'h20, 1'b1);
      first_run(1, 32);
    join
    check_window("t6");

    // Randomised command stream
    for (int it = 0; it < 4; it++) begin
      mode = int'($urandom_range(0, 3));
      if (mode <= 1) begin
        b = {4'hA, 2'b00, 2'($urandom_range(0, NCH - 1))};
        send(b);
        idle(int'($urandom_range(2, 150)));
        send(8'($urandom_range(0, 255)));
      end else if (mode == 2) begin
        send(8'($urandom_range(0, 255)));
      end else begin
        b = {4'hA, 2'b00, 2'($urandom_range(0, NCH - 1))};
        send(b);
        idle(LONG_GAP);
      end
      idle(int'($urandom_range(2, 150)));
    end
    check_window("rand");
    check("final_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
